// File: rtl/risc_processor.sv
// Single-cycle 16-bit RISC core with a fixed program in ROM, 8x16 register file and 16x16 data RAM.
// One instruction retires per rising clock edge; only the registered zero flag leaves the block.
module risc_processor (
  input  logic clock,
  input  logic reset,
  output logic zero
);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpSlt  = 4'h5;
  localparam logic [3:0] OpAddi = 4'h6;
  localparam logic [3:0] OpLw   = 4'h7;
  localparam logic [3:0] OpSw   = 4'h8;
  localparam logic [3:0] OpBeq  = 4'h9;
  localparam logic [3:0] OpJ    = 4'hA;

  logic [7:0]  pc_q, pc_d;
  logic        zero_q, zero_d;
  logic [15:0] regs_q [8];
  logic [15:0] mem_q [16];

  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm6;
  logic [7:0]  imm8;
  logic [15:0] rd_val, rs1_val, rs2_val;
  logic [15:0] sum_imm;
  logic [15:0] wb_data;
  logic        reg_we, mem_we;

  // Fixed program; unlisted slots are NOPs.
  always_comb begin
    instr = 16'hF000;
    unique case (pc_q[4:0])
      5'd0:    instr = 16'h6205;
      5'd1:    instr = 16'h6405;
      5'd2:    instr = 16'h1650;
      5'd3:    instr = 16'h8200;
      5'd4:    instr = 16'h7800;
      5'd5:    instr = 16'h9601;
      5'd6:    instr = 16'h6A01;
      5'd7:    instr = 16'h0B08;
      5'd8:    instr = 16'hA008;
      default: instr = 16'hF000;
    endcase
  end

  assign opcode = instr[15:12];
  assign rd     = instr[11:9];
  assign rs1    = instr[8:6];
  assign rs2    = instr[5:3];
  assign imm6   = {{10{instr[5]}}, instr[5:0]};
  assign imm8   = instr[7:0];

  assign rd_val  = (rd  == 3'd0) ? 16'h0000 : regs_q[rd];
  assign rs1_val = (rs1 == 3'd0) ? 16'h0000 : regs_q[rs1];
  assign rs2_val = (rs2 == 3'd0) ? 16'h0000 : regs_q[rs2];

  // Shared by ADDI and the LW/SW address calculation.
  assign sum_imm = rs1_val + imm6;

  always_comb begin
    wb_data = 16'h0000;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    zero_d  = zero_q;
    pc_d    = pc_q + 8'd1;
    case (opcode)
      OpAdd:  begin wb_data = rs1_val + rs2_val; reg_we = 1'b1; end
      OpSub:  begin wb_data = rs1_val - rs2_val; reg_we = 1'b1; end
      OpAnd:  begin wb_data = rs1_val & rs2_val; reg_we = 1'b1; end
      OpOr:   begin wb_data = rs1_val | rs2_val; reg_we = 1'b1; end
      OpXor:  begin wb_data = rs1_val ^ rs2_val; reg_we = 1'b1; end
      OpSlt:  begin
        wb_data = {15'd0, $signed(rs1_val) < $signed(rs2_val)};
        reg_we  = 1'b1;
      end
      OpAddi: begin wb_data = sum_imm; reg_we = 1'b1; end
      OpLw:   begin wb_data = mem_q[sum_imm[3:0]]; reg_we = 1'b1; end
      OpSw:   mem_we = 1'b1;
      OpBeq:  begin
        zero_d = (rd_val == rs1_val);
        if (rd_val == rs1_val) pc_d = pc_q + 8'd1 + imm6[7:0];
      end
      OpJ:    pc_d = imm8;
      default: ;
    endcase
    if (opcode <= OpAddi) zero_d = (wb_data == 16'h0000);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= 8'd0;
      zero_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
      for (int i = 0; i < 16; i++) mem_q[i] <= 16'h0000;
    end else begin
      pc_q   <= pc_d;
      zero_q <= zero_d;
      if (reg_we && rd != 3'd0) regs_q[rd] <= wb_data;
      if (mem_we) mem_q[sum_imm[3:0]] <= rd_val;
    end
  end

  assign zero = zero_q;

endmodule

// File: tb/tb_risc_processor.sv
// Directed bench for risc_processor: steps the fixed program edge by edge and checks the zero
// flag plus internal pc, registers and data RAM against hand-traced values.
module tb_risc_processor;

  logic clock;
  logic reset;
  logic zero;

  int n_checks;
  int n_errors;

  risc_processor dut (
    .clock (clock),
    .reset (reset),
    .zero  (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " zero"}, {15'd0, zero}, 16'd0);
    check({tag, " pc"}, {8'd0, dut.pc_q}, 16'd0);
    for (int i = 1; i < 8; i++) check($sformatf("%s r%0d", tag, i), dut.regs_q[i], 16'd0);
    check({tag, " mem0"}, dut.mem_q[0], 16'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;

    step(2);
    check_cleared("reset");

    reset = 1'b0;
    step(2);
    check("r1 after addi", dut.regs_q[1], 16'd5);
    check("r2 after addi", dut.regs_q[2], 16'd5);
    check("zero after addi", {15'd0, zero}, 16'd0);
    check("pc edge2", {8'd0, dut.pc_q}, 16'd2);

    step(1);
    check("r3 after sub", dut.regs_q[3], 16'd0);
    check("zero after sub", {15'd0, zero}, 16'd1);

    step(1);
    check("mem0 after sw", dut.mem_q[0], 16'd5);
    check("zero after sw", {15'd0, zero}, 16'd1);

    step(1);
    check("r4 after lw", dut.regs_q[4], 16'd5);
    check("zero after lw", {15'd0, zero}, 16'd1);

    step(1);
    check("pc after beq", {8'd0, dut.pc_q}, 16'd7);
    check("zero after beq", {15'd0, zero}, 16'd1);

    step(1);
    check("r5 after add", dut.regs_q[5], 16'd10);
    check("zero after add", {15'd0, zero}, 16'd0);
    check("pc after add", {8'd0, dut.pc_q}, 16'd8);

    for (int k = 0; k < 5; k++) begin
      step(1);
      check($sformatf("loop pc %0d", k), {8'd0, dut.pc_q}, 16'd8);
      check($sformatf("loop zero %0d", k), {15'd0, zero}, 16'd0);
    end
    check("r5 stable", dut.regs_q[5], 16'd10);

    // Restart, run to edge 4, then reset mid-program.
    reset = 1'b1;
    step(1);
    check_cleared("restart");
    reset = 1'b0;
    step(4);
    check("mid pc", {8'd0, dut.pc_q}, 16'd4);
    check("mid mem0", dut.mem_q[0], 16'd5);
    check("mid zero", {15'd0, zero}, 16'd1);

    reset = 1'b1;
    step(1);
    check_cleared("midreset");

    reset = 1'b0;
    step(2);
    check("replay zero edge2", {15'd0, zero}, 16'd0);
    check("replay r1", dut.regs_q[1], 16'd5);
    step(1);
    check("replay zero edge3", {15'd0, zero}, 16'd1);
    check("replay r3", dut.regs_q[3], 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
